// File: rtl/gather_bpsk_if.sv
// gather_bpsk_if: serial-bit input, word output and status bundle for gather_bpsk
interface gather_bpsk_if #(parameter int WIDTH = 32);
  logic             valid_i;
  logic             data_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             ack_o;
  logic             short_o;
  logic             overrun_o;
  logic [15:0]      words_o;
  modport master (output valid_i, data_i, ack_o, input valid_o, data_o, short_o, overrun_o, words_o);
  modport slave (input valid_i, data_i, ack_o, output valid_o, data_o, short_o, overrun_o, words_o);
endinterface

// File: rtl/gather_bpsk.sv
// gather_bpsk: assembles LSB-first serial bits into WIDTH-bit words behind a one-word output register
module gather_bpsk #(
  parameter int WIDTH = 32
) (
  input logic              CLK,
  input logic              RST,
  gather_bpsk_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {S_IDLE, S_FILL} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shift;
  logic             short_n, done, load;
  // every accepted bit enters at the MSB, so after WIDTH-1 bits the first one sits at shift[1]
  always_ff @(posedge CLK)
    if (RST && bus.valid_i) shift <= {bus.data_i, shift[WIDTH-1:1]};
  always_comb begin
    state_n = bus.valid_i ? S_FILL : S_IDLE;
    cnt_n   = !bus.valid_i ? '0 : state == S_IDLE ? CW'(1) : cnt == LAST ? '0 : cnt + CW'(1);
    short_n = state == S_FILL && !bus.valid_i && cnt != '0;
    done    = state == S_FILL && bus.valid_i && cnt == LAST;
    load    = done && (!bus.valid_o || bus.ack_o);
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.valid_o   <= 1'b0;
      bus.data_o    <= '0;
      bus.short_o   <= 1'b0;
      bus.overrun_o <= 1'b0;
      bus.words_o   <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus.short_o   <= short_n;
      bus.valid_o   <= load || (bus.valid_o && !bus.ack_o);
      bus.overrun_o <= bus.overrun_o || (done && !load);
      if (load) begin
        bus.data_o  <= {bus.data_i, shift[WIDTH-1:1]};
        bus.words_o <= bus.words_o + 16'(bus.words_o != 16'hFFFF);
      end
    end
  end
endmodule

// File: tb/tb_gather_bpsk.sv
// tb_gather_bpsk: directed vectors for gather_bpsk with hand-computed expectations
module tb_gather_bpsk;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int total = 0;
  int bad = 0;
  gather_bpsk_if #(.WIDTH(32)) bus();
  gather_bpsk #(.WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    tick();
  endtask
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask
  task automatic idle();
    bus.valid_i = 1'b0;
    bus.data_i  = 1'b0;
    tick();
  endtask
  task automatic do_reset();
    RST = 1'b0;
    idle();
    idle();
    RST = 1'b1;
  endtask
  logic [31:0] ws [3];
  int pulses, shorts;
  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 1'b0;
    bus.ack_o   = 1'b1;
    ws[0] = 32'h1234_5678;
    ws[1] = 32'hDEAD_BEEF;
    ws[2] = 32'h0F0F_55AA;
    do_reset();
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_words", 32'(bus.words_o), 32'd0);
    chk("rst_short", 32'(bus.short_o), 32'd0);
    chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
    send_bits(32'hA5C3_0F81, 31);
    chk("single_early", 32'(bus.valid_o), 32'd0);
    send_bit(1'b1);
    chk("single_valid", 32'(bus.valid_o), 32'd1);
    chk("single_data", bus.data_o, 32'hA5C3_0F81);
    chk("single_words", 32'(bus.words_o), 32'd1);
    idle();
    chk("single_clear", 32'(bus.valid_o), 32'd0);
    chk("single_noshort", 32'(bus.short_o), 32'd0);
    do_reset();
    pulses = 0;
    shorts = 0;
    for (int i = 0; i < 96; i++) begin
      send_bit(ws[i / 32][i % 32]);
      if (bus.short_o) shorts++;
      if (bus.valid_o) pulses++;
      if (i % 32 == 31) begin
        chk("stream_valid", 32'(bus.valid_o), 32'd1);
        chk("stream_data", bus.data_o, ws[i / 32]);
      end
    end
    idle();
    if (bus.short_o) shorts++;
    chk("stream_pulses", 32'(pulses), 32'd3);
    chk("stream_shorts", 32'(shorts), 32'd0);
    chk("stream_words", 32'(bus.words_o), 32'd3);
    do_reset();
    send_bits(32'h0001_FFFF, 17);
    idle();
    chk("short_pulse", 32'(bus.short_o), 32'd1);
    chk("short_novalid", 32'(bus.valid_o), 32'd0);
    idle();
    chk("short_end", 32'(bus.short_o), 32'd0);
    send_bits(32'hCAFE_F00D, 32);
    chk("short_next_valid", 32'(bus.valid_o), 32'd1);
    chk("short_next_data", bus.data_o, 32'hCAFE_F00D);
    chk("short_next_words", 32'(bus.words_o), 32'd1);
    do_reset();
    bus.ack_o = 1'b0;
    send_bits(32'h1357_9BDF, 32);
    chk("ovr_first_valid", 32'(bus.valid_o), 32'd1);
    chk("ovr_first_flag", 32'(bus.overrun_o), 32'd0);
    send_bits(32'h2468_ACE0, 31);
    chk("ovr_pre_flag", 32'(bus.overrun_o), 32'd0);
    send_bit(1'b0);
    chk("ovr_flag", 32'(bus.overrun_o), 32'd1);
    chk("ovr_data", bus.data_o, 32'h1357_9BDF);
    chk("ovr_words", 32'(bus.words_o), 32'd1);
    chk("ovr_valid", 32'(bus.valid_o), 32'd1);
    bus.ack_o = 1'b1;
    idle();
    bus.ack_o = 1'b0;
    chk("ovr_ack_clear", 32'(bus.valid_o), 32'd0);
    idle();
    chk("ovr_sticky", 32'(bus.overrun_o), 32'd1);
    do_reset();
    bus.ack_o = 1'b0;
    send_bits(32'h8000_0001, 32);
    pulses = 0;
    for (int i = 0; i < 31; i++) begin
      send_bit(ws[1][i]);
      if (bus.valid_o) pulses++;
    end
    chk("sim_held", 32'(pulses), 32'd31);
    bus.ack_o = 1'b1;
    send_bit(ws[1][31]);
    bus.ack_o = 1'b0;
    chk("sim_valid", 32'(bus.valid_o), 32'd1);
    chk("sim_data", bus.data_o, 32'hDEAD_BEEF);
    chk("sim_overrun", 32'(bus.overrun_o), 32'd0);
    chk("sim_words", 32'(bus.words_o), 32'd2);
    do_reset();
    bus.ack_o = 1'b1;
    send_bits(32'h0000_03FF, 10);
    RST = 1'b0;
    send_bit(1'b1);
    RST = 1'b1;
    chk("mid_valid", 32'(bus.valid_o), 32'd0);
    chk("mid_short", 32'(bus.short_o), 32'd0);
    chk("mid_words", 32'(bus.words_o), 32'd0);
    idle();
    chk("mid_short_after", 32'(bus.short_o), 32'd0);
    send_bits(32'h5A5A_C3C3, 32);
    chk("mid_next_valid", 32'(bus.valid_o), 32'd1);
    chk("mid_next_data", bus.data_o, 32'h5A5A_C3C3);
    chk("mid_next_words", 32'(bus.words_o), 32'd1);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gather_bpsk.md
GATHER_BPSK -- requirements
Module: gather_bpsk

Interface
REQ-001 Parameter: WIDTH, 32, bits per assembled word; legal range 2..32.
REQ-002 Port: CLK  input  1  single clock; all logic on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-low.
REQ-004 Port: valid_i  input  1  serial bit qualifier; high = data_i carries a bit this cycle.
REQ-005 Port: data_i  input  1  serial bit, LSB of each word first.
REQ-006 Port: valid_o  output  1  data_o holds a complete, unconsumed word.
REQ-007 Port: data_o  output  WIDTH  assembled word, bit k = k-th received bit of the word.
REQ-008 Port: ack_o  input  1  consumer accepts data_o in any cycle where valid_o and ack_o are both high.
REQ-009 Port: short_o  output  1  one-cycle pulse: a partial word was discarded.
REQ-010 Port: overrun_o  output  1  sticky: a completed word was dropped because the output was still full.
REQ-011 Port: words_o  output  16  count of words delivered to the output register; saturates at 16'hFFFF.

Function
REQ-012 States SHALL be S_IDLE (no bits pending) and S_FILL (word in progress or back-to-back stream).
REQ-013 S_IDLE -> S_FILL on valid_i high; that bit SHALL be captured as bit 0 and the bit counter set to 1.
REQ-014 In S_FILL, each cycle with valid_i high SHALL shift data_i into the shift register MSB, shifting right, and increment the counter modulo WIDTH.
REQ-015 Cycle with valid_i high and counter == WIDTH-1 SHALL complete a word: {data_i, shift[WIDTH-1:1]}; counter wraps to 0 and the state stays S_FILL.
REQ-016 S_FILL with valid_i low and counter == 0 SHALL return to S_IDLE with no error.
REQ-017 S_FILL with valid_i low and counter != 0 SHALL return to S_IDLE, clear counter, discard the partial word, and pulse short_o high for exactly the next cycle.
REQ-018 On word completion, if valid_o is low or (valid_o and ack_o) in that cycle, data_o SHALL load the word and valid_o SHALL be high on the next cycle; latency from the last bit's edge to valid_o = 1 cycle.
REQ-019 On word completion with valid_o high and ack_o low, the new word SHALL be dropped, data_o unchanged, and overrun_o set and held until reset.
REQ-020 valid_o and data_o SHALL remain stable while valid_o is high and ack_o is low.
REQ-021 valid_o SHALL clear the cycle after acceptance unless a word completes in the same cycle (REQ-018), in which case valid_o stays high with the new word.
REQ-022 words_o SHALL increment by 1 on every load of data_o (REQ-018), saturating at 16'hFFFF; dropped words are not counted.
REQ-023 Input has no backpressure; bits are never stalled and a word completion is never delayed.
REQ-024 The shift register needs no reset; its contents SHALL never reach data_o except via REQ-015.

Reset
REQ-025 With RST low at a clock edge, state = S_IDLE, counter = 0, valid_o = 0, short_o = 0, overrun_o = 0, words_o = 0, data_o = 0.
REQ-026 Reset mid-word SHALL discard the partial word without a short_o pulse; reset while valid_o is high SHALL drop the held word.
REQ-027 valid_i and ack_o SHALL be ignored in any cycle where RST is low.

Verification
REQ-028 Single word: serialize 32'hA5C3_0F81 LSB-first over 32 consecutive valid_i cycles, ack_o held high -> valid_o high for 1 cycle, one cycle after the last bit, data_o = 32'hA5C3_0F81, words_o = 1.
REQ-029 Back-to-back stream: 3 words, 96 continuous valid_i cycles, ack_o = 1 -> three valid_o pulses spaced 32 cycles apart, correct data, short_o never high, words_o = 3.
REQ-030 Short frame: 17 bits then valid_i low -> short_o high for exactly 1 cycle, valid_o stays low; the next full 32-bit word is received correctly.
REQ-031 Overrun: ack_o = 0, send 2 full words -> data_o = first word and held, overrun_o = 1 after the 64th bit, words_o = 1; after ack_o pulses, valid_o clears.
REQ-032 Simultaneous accept and complete: ack_o high in the cycle the second word completes -> valid_o continuously high, data_o switches to the second word, overrun_o = 0.
REQ-033 Reset mid-word: 10 bits, RST low for 1 cycle -> all outputs at reset values, no short_o; a subsequent full word is received correctly.
